// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response signals of alu_issue_ctrl.
// slave is the controller's view; master is the surrounding datapath/ALU view.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_src1;
  logic [WIDTH-1:0] req_src2;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_cout;
  logic             rsp_overflow;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req_valid, req_src1, req_src2, req_op,
    input  alu_result, alu_zero, alu_cout, alu_overflow,
    input  rsp_ready,
    output req_ready, alu_src1, alu_src2, alu_ctrl,
    output rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
    output busy
  );

  modport master (
    output req_valid, req_src1, req_src2, req_op,
    output alu_result, alu_zero, alu_cout, alu_overflow,
    output rsp_ready,
    input  req_ready, alu_src1, alu_src2, alu_ctrl,
    input  rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
    input  busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue operands to a registered ALU and collect results into an in-order response FIFO.
// Latency: response visible 3 edges after accept; one op per cycle sustained.
// Backpressure: req_ready is a registered credit check, so the FIFO never overflows.
module alu_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_rdy && (count_q != '0);
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push_vld) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_vld = (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_issue_ctrl_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             err;
  } rsp_t;

  typedef struct packed {
    logic vld;
    logic err;
    logic arith;
  } tag_t;

  tag_t             s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             rdy_en_q, rdy_en_d;
  logic             op_legal, op_arith, accept, req_rdy;
  logic [AW+1:0]    credits_used;
  logic             push_vld;
  rsp_t             push_dat, head;
  logic             head_vld;
  logic [AW:0]      fifo_count;

  always_comb begin
    op_legal = 1'b0;
    case (io.req_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
    op_arith = (io.req_op == OP_ADD) || (io.req_op == OP_SUB);

    // Every op in s1/s2 already owns a FIFO slot, so counting them keeps pushes lossless.
    credits_used = (AW+2)'(fifo_count) + (AW+2)'(s1_q.vld) + (AW+2)'(s2_q.vld);
    req_rdy      = rdy_en_q && (credits_used < (AW+2)'(DEPTH));
    accept       = io.req_valid && req_rdy;
    rdy_en_d     = 1'b1;

    src1_d = src1_q;
    src2_d = src2_q;
    ctrl_d = ctrl_q;
    s1_d   = '0;
    if (accept) begin
      s1_d.vld   = 1'b1;
      s1_d.err   = !op_legal;
      s1_d.arith = op_arith;
      if (op_legal) begin
        src1_d = io.req_src1;
        src2_d = io.req_src2;
        ctrl_d = io.req_op;
      end
    end
    s2_d = s1_q;

    push_vld = s2_q.vld;
    push_dat = '0;
    if (s2_q.err) begin
      push_dat.err = 1'b1;
    end else begin
      push_dat.result = io.alu_result;
      push_dat.zero   = io.alu_zero;
      if (s2_q.arith) begin
        push_dat.cout     = io.alu_cout;
        push_dat.overflow = io.alu_overflow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  alu_issue_fifo #(.W($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (io.rsp_ready),
    .pop_vld  (head_vld),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  assign io.req_ready    = req_rdy;
  assign io.alu_src1     = src1_q;
  assign io.alu_src2     = src2_q;
  assign io.alu_ctrl     = ctrl_q;
  assign io.rsp_valid    = head_vld;
  assign io.rsp_result   = head.result;
  assign io.rsp_zero     = head.zero;
  assign io.rsp_cout     = head.cout;
  assign io.rsp_overflow = head.overflow;
  assign io.rsp_err      = head.err;
  assign io.busy         = s1_q.vld | s2_q.vld | (fifo_count != '0);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU model, table vectors, corner sequences,
// and random traffic checked against an outstanding-request queue model.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        e;
  } rsp_t;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
  } alu_out_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rsp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(WIDTH)) ifc();
  alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .io(ifc));

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   post_edges;
  rsp_t exp_q[$];
  rsp_t cap_q[$];
  rsp_t want_q[$];
  logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t   r;
    logic [32:0] s;
    r = '0;
    s = '0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0010: begin
        s     = {1'b0, a} + {1'b0, b};
        r.res = s[31:0];
        r.c   = s[32];
        r.o   = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110: begin
        s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.res = s[31:0];
        r.c   = s[32];
        r.o   = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r.res = ~(a | b);
      default: r.res = '0;
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  function automatic rsp_t mk(input logic [31:0] r, input logic z, input logic c, input logic o, input logic e);
    return {r, z, c, o, e};
  endfunction

  function automatic rsp_t exp_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t x;
    if (!is_legal(op)) return mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    x = alu_fn(op, a, b);
    if (op == 4'b0010 || op == 4'b0110) return mk(x.res, x.z, x.c, x.o, 1'b0);
    return mk(x.res, x.z, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic rsp_t dut_rsp();
    return mk(ifc.rsp_result, ifc.rsp_zero, ifc.rsp_cout, ifc.rsp_overflow, ifc.rsp_err);
  endfunction

  // Registered ALU; logic ops emit junk carry/overflow that the controller must mask.
  alu_out_t alu_next;
  assign alu_next = alu_fn(ifc.alu_ctrl, ifc.alu_src1, ifc.alu_src2);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.alu_result   <= '0;
      ifc.alu_zero     <= 1'b0;
      ifc.alu_cout     <= 1'b0;
      ifc.alu_overflow <= 1'b0;
    end else begin
      ifc.alu_result   <= alu_next.res;
      ifc.alu_zero     <= alu_next.z;
      if (ifc.alu_ctrl == 4'b0010 || ifc.alu_ctrl == 4'b0110) begin
        ifc.alu_cout     <= alu_next.c;
        ifc.alu_overflow <= alu_next.o;
      end else begin
        ifc.alu_cout     <= 1'($urandom_range(0, 1));
        ifc.alu_overflow <= 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ifc.req_valid = v;
    ifc.req_op    = op;
    ifc.req_src1  = a;
    ifc.req_src2  = b;
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_count"}, 64'(cap_q.size()), 64'(want_q.size()));
    for (int i = 0; i < want_q.size(); i++) begin
      if (i < cap_q.size()) begin
        chk($sformatf("%s_%0d", tag, i), cap_q[i], want_q[i]);
      end else begin
        checks++;
        errors++;
        $display("FAIL %s_%0d actual=missing required=%h", tag, i, want_q[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, ifc.req_ready, 0);
    chk({tag, "_rsp_valid"}, ifc.rsp_valid, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_alu_src1"}, ifc.alu_src1, 0);
    chk({tag, "_alu_src2"}, ifc.alu_src2, 0);
    chk({tag, "_alu_ctrl"}, ifc.alu_ctrl, 0);
    chk({tag, "_rsp"}, dut_rsp(), 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) post_edges <= 0;
    else if (post_edges < 2) post_edges <= post_edges + 1;
  end

  // Outstanding = accepted but not yet popped; this alone defines ready and busy.
  always @(negedge clk) begin : mon
    rsp_t got;
    if (rst_n && mon_en) begin
      chk("req_ready_credit", ifc.req_ready, (post_edges >= 1) && (exp_q.size() < DEPTH));
      chk("busy_model", ifc.busy, exp_q.size() != 0);
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        got = dut_rsp();
        cap_q.push_back(got);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%h required=none", got);
        end else begin
          chk("rsp_order", got, exp_q.pop_front());
        end
      end
      if (ifc.req_valid && ifc.req_ready) exp_q.push_back(exp_of(ifc.req_op, ifc.req_src1, ifc.req_src2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[14];
  int   n, idx, acc;
  bit   seen;

  initial begin
    vt[0]  = '{4'b0010, 32'h00000005, 32'h00000003, mk(32'h00000008, 0, 0, 0, 0)};
    vt[1]  = '{4'b0110, 32'h00000007, 32'h00000007, mk(32'h00000000, 1, 1, 0, 0)};
    vt[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 0, 0, 1, 0)};
    vt[3]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 0, 0, 0, 0)};
    vt[4]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hFFF0FFF0, 0, 0, 0, 0)};
    vt[5]  = '{4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h00000000, 0, 0, 0, 1)};
    vt[6]  = '{4'b1100, 32'h00000000, 32'h00000000, mk(32'hFFFFFFFF, 0, 0, 0, 0)};
    vt[7]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000001, 0, 0, 0, 0)};
    vt[8]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, mk(32'h00000000, 1, 0, 0, 0)};
    vt[9]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 1, 1, 0, 0)};
    vt[10] = '{4'b0110, 32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 0, 1, 1, 0)};
    vt[11] = '{4'b0110, 32'h00000000, 32'h00000001, mk(32'hFFFFFFFF, 0, 0, 0, 0)};
    vt[12] = '{4'b1111, 32'h00000005, 32'h00000005, mk(32'h00000000, 0, 0, 0, 1)};
    vt[13] = '{4'b1100, 32'hFFFFFFFF, 32'h00000000, mk(32'h00000000, 1, 0, 0, 0)};

    drv(0, 4'b0000, 0, 0);
    ifc.rsp_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", ifc.req_ready, 0);
    tick();
    chk("ready_after_first_edge", ifc.req_ready, 1);
    mon_en = 1'b1;

    // Table vectors, one at a time, with latency measured from the accepting edge.
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      drv(1, vt[i].op, vt[i].a, vt[i].b);
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(posedge clk);
        n++;
        #1;
        if (n == 1) ifc.req_valid = 1'b0;
        @(negedge clk);
        if (ifc.rsp_valid) seen = 1'b1;
      end
      chk($sformatf("latency_vec%0d", i), 64'(n), 3);
      chk($sformatf("vec%0d", i), dut_rsp(), vt[i].exp);
    end

    // Illegal op between AND and OR: order kept, ALU registers hold during the illegal slot.
    tick();
    cap_q.delete();
    drv(1, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    drv(1, 4'b0101, 32'h12345678, 32'h9ABCDEF0);
    tick();
    chk("illegal_hold_ctrl", ifc.alu_ctrl, 4'b0000);
    chk("illegal_hold_src2", ifc.alu_src2, 32'hFF00FF00);
    drv(1, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    chk("or_loads_ctrl", ifc.alu_ctrl, 4'b0001);
    drv(0, 4'b0000, 0, 0);
    repeat (6) tick();
    want_q.delete();
    want_q.push_back(mk(32'hF000F000, 0, 0, 0, 0));
    want_q.push_back(mk(32'h00000000, 0, 0, 0, 1));
    want_q.push_back(mk(32'hFFF0FFF0, 0, 0, 0, 0));
    check_cap("illegal_seq");

    // Backpressure: 6 requests with rsp_ready low, then drain.
    cap_q.delete();
    ifc.rsp_ready = 1'b0;
    idx = 1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      drv(idx <= 6, 4'b0010, 32'(idx), 32'd0);
      @(negedge clk);
      if (ifc.req_valid && ifc.req_ready) begin
        idx++;
        acc++;
      end
    end
    chk("bp_accepted", 64'(acc), 4);
    chk("bp_ready_low", ifc.req_ready, 0);
    for (int k = 0; k < 30; k++) begin
      tick();
      ifc.rsp_ready = 1'b1;
      drv(idx <= 6, 4'b0010, 32'(idx), 32'd0);
      @(negedge clk);
      if (k == 0) chk("bp_ready_before_pop", ifc.req_ready, 0);
      if (k == 1) chk("bp_ready_after_pop", ifc.req_ready, 1);
      if (ifc.req_valid && ifc.req_ready) idx++;
    end
    drv(0, 4'b0000, 0, 0);
    want_q.delete();
    for (int i = 1; i <= 6; i++) want_q.push_back(mk(32'(i), 0, 0, 0, 0));
    check_cap("bp_drain");

    // Push and pop on the same edge with DEPTH-1 entries queued.
    tick();
    cap_q.delete();
    ifc.rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drv(1, 4'b0010, 32'(8'h11 * i), 32'd0);
      tick();
    end
    drv(0, 4'b0000, 0, 0);
    repeat (4) tick();
    drv(1, 4'b0010, 32'h44, 32'd0);
    tick();
    drv(0, 4'b0000, 0, 0);
    tick();
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    chk("simul_popped_one", 64'(cap_q.size()), 1);
    drv(1, 4'b0010, 32'h55, 32'd0);
    tick();
    drv(0, 4'b0000, 0, 0);
    @(negedge clk);
    chk("simul_full_ready", ifc.req_ready, 0);
    tick();
    ifc.rsp_ready = 1'b1;
    repeat (10) tick();
    want_q.delete();
    for (int i = 1; i <= 5; i++) want_q.push_back(mk(32'(8'h11 * i), 0, 0, 0, 0));
    check_cap("simul");

    // Reset with 2 ops in flight and 2 queued.
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 4'b0010, 32'(100 + i), 32'd1);
      tick();
    end
    drv(0, 4'b0000, 0, 0);
    chk("pre_reset_busy", ifc.busy, 1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    cap_q.delete();
    ifc.rsp_ready = 1'b1;
    #7;
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_rsp_valid_%0d", k), ifc.rsp_valid, 0);
      chk($sformatf("post_reset_busy_%0d", k), ifc.busy, 0);
    end

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      tick();
      ifc.req_valid = ($urandom_range(0, 9) < 7);
      idx = int'($urandom_range(0, 15));
      ifc.req_op = (idx < 12) ? legal_ops[idx % 6] : 4'($urandom);
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 5))
          0:       n = 0;
          1:       n = -1;
          2:       n = int'(32'h80000000);
          3:       n = int'(32'h7FFFFFFF);
          default: n = int'($urandom);
        endcase
        if (j == 0) ifc.req_src1 = 32'(n);
        else        ifc.req_src2 = 32'(n);
      end
      ifc.rsp_ready = ($urandom_range(0, 9) < 6);
    end
    drv(0, 4'b0000, 0, 0);
    ifc.rsp_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    repeat (2) tick();
    chk("random_drain_empty", 64'(exp_q.size()), 0);
    chk("random_drain_rsp_valid", ifc.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
